ff_stream_serializer: RTL and testbench



---
 rtl/ff_stream_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_ff_stream_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_stream_serializer.sv
// Byte FIFO feeding an MSB-first serial bit stream; FF_PRBS_TEST_EN adds a PRBS-7 test mode.
// Latency: byte written into empty FIFO on edge N shows bit 7 after edge N+1.
// Backpressure: writes while full are dropped and flag sticky overflow.

// Generic byte FIFO with registered full/empty/level and sticky overflow.
// Latency: written byte readable (rd_dat_o) the cycle after the write edge.
// Backpressure: wr_vld_i ignored while full; pop_i ignored while empty.
module ff_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          wr_vld_i,
   input  logic [7:0]    wr_dat_i,
   input  logic          pop_i,
   output logic [7:0]    rd_dat_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o,
   output logic          overflow_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          full_q, empty_q, overflow_q;
   logic          wr_acc, pop_acc;

   // Acceptance uses the registered flags, so a full FIFO drops a write even if it pops this edge.
   assign wr_acc  = wr_vld_i & ~full_q;
   assign pop_acc = pop_i & ~empty_q;

   always_comb begin
      level_d = level_q;
      case ({wr_acc, pop_acc})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (wr_acc)  wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (wr_vld_i && full_q) overflow_q <= 1'b1;
         level_q <= level_d;
         full_q  <= (level_d == (AW+1)'(DEPTH));
         empty_q <= (level_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_dat_i;
   end

   assign rd_dat_o   = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign level_o    = level_q;
   assign overflow_o = overflow_q;

endmodule

// Serial sink feeder: pops bytes and shifts them out MSB-first, back-to-back, with ff_en.
// Latency: one cycle from FIFO non-empty to bit 7; 8 cycles per byte, no gaps.
// Backpressure: none on the serial side; writer must honour full (overflow is sticky).
module ff_stream_serializer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              ff_clk,
   input  logic              reset,
`ifdef FF_PRBS_TEST_EN
   input  logic              prbs_mode,
`endif
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              ff_data,
   output logic              ff_en,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PRBS  = 2'd2
   } state_t;

   state_t     state_q;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       ff_data_q, ff_en_q, busy_q;
   logic [7:0] rd_data;
   logic       pop_slot, pop;

   ff_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (ADDR_W)
   ) u_fifo (
      .clk_i      (ff_clk),
      .reset_i    (reset),
      .wr_vld_i   (wr_en),
      .wr_dat_i   (wr_data),
      .pop_i      (pop),
      .rd_dat_o   (rd_data),
      .full_o     (full),
      .empty_o    (empty),
      .level_o    (level),
      .overflow_o (overflow)
   );

   assign pop_slot = (state_q == S_IDLE) || ((state_q == S_SHIFT) && (bit_cnt_q == 3'd0));

`ifdef FF_PRBS_TEST_EN
   logic [6:0] lfsr_q;
   logic [6:0] lfsr_nxt;

   assign lfsr_nxt = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   assign pop      = pop_slot & ~empty & ~prbs_mode;
`else
   assign pop      = pop_slot & ~empty;
`endif

   always_ff @(posedge ff_clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         ff_data_q <= 1'b0;
         ff_en_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef FF_PRBS_TEST_EN
         lfsr_q    <= 7'h7F;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  state_q   <= S_SHIFT;
                  shift_q   <= rd_data;
                  bit_cnt_q <= 3'd7;
                  ff_data_q <= rd_data[7];
                  ff_en_q   <= 1'b1;
                  busy_q    <= 1'b1;
`ifdef FF_PRBS_TEST_EN
               end else if (prbs_mode) begin
                  state_q   <= S_PRBS;
                  ff_data_q <= lfsr_q[6];
                  ff_en_q   <= 1'b1;
                  lfsr_q    <= lfsr_nxt;
`endif
               end else begin
                  ff_data_q <= 1'b0;
                  ff_en_q   <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (bit_cnt_q != 3'd0) begin
                  // shift_q[7] is already on the wire, so the next bit sits at [6].
                  bit_cnt_q <= bit_cnt_q - 3'd1;
                  ff_data_q <= shift_q[6];
                  shift_q   <= {shift_q[6:0], 1'b0};
               end else if (pop) begin
                  shift_q   <= rd_data;
                  bit_cnt_q <= 3'd7;
                  ff_data_q <= rd_data[7];
`ifdef FF_PRBS_TEST_EN
               end else if (prbs_mode) begin
                  state_q   <= S_PRBS;
                  ff_data_q <= lfsr_q[6];
                  busy_q    <= 1'b0;
                  lfsr_q    <= lfsr_nxt;
`endif
               end else begin
                  state_q   <= S_IDLE;
                  ff_data_q <= 1'b0;
                  ff_en_q   <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
`ifdef FF_PRBS_TEST_EN
            S_PRBS: begin
               if (prbs_mode) begin
                  ff_data_q <= lfsr_q[6];
                  ff_en_q   <= 1'b1;
                  lfsr_q    <= lfsr_nxt;
               end else begin
                  state_q   <= S_IDLE;
                  ff_data_q <= 1'b0;
                  ff_en_q   <= 1'b0;
                  lfsr_q    <= 7'h7F;
               end
            end
`endif
            default: begin
               state_q   <= S_IDLE;
               ff_data_q <= 1'b0;
               ff_en_q   <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ff_data = ff_data_q;
   assign ff_en   = ff_en_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_ff_stream_serializer.sv
// Bench for ff_stream_serializer: bit scoreboard, per-byte vector table, and hand-built corner sequences.
module tb_ff_stream_serializer;

   logic       ff_clk = 1'b0;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full, empty, overflow, ff_data, ff_en, busy;
   logic [3:0] level;
`ifdef FF_PRBS_TEST_EN
   logic       prbs_mode = 1'b0;
`endif

   ff_stream_serializer #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
      .ff_clk   (ff_clk),
      .reset    (reset),
`ifdef FF_PRBS_TEST_EN
      .prbs_mode(prbs_mode),
`endif
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .ff_data  (ff_data),
      .ff_en    (ff_en),
      .busy     (busy)
   );

   always #5 ff_clk = ~ff_clk;

   int   checks = 0;
   int   errors = 0;
   logic sb[$];
   logic exp_b;
   bit   mon_on  = 1'b0;
   bit   prbs_on = 1'b0;
   int   run_len, max_run, runs, en_total, zero_len, last_gap;

   typedef struct {
      logic [7:0] dat;
      logic [7:0] exp_bits;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ff_clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit acc);
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge ff_clk);
      if (acc) for (int i = 7; i >= 0; i--) sb.push_back(d[i]);
      #1 wr_en = 1'b0;
   endtask

   task automatic stats_clr();
      #1;
      run_len = 0; max_run = 0; runs = 0; en_total = 0; zero_len = 0; last_gap = 0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge ff_clk);
         n++;
      end while (!(!ff_en && empty && !busy) && n < 300);
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL %s: idle not reached within %0d cycles", name, n);
      end
   endtask

   // Every serial bit is checked against the scoreboard; run/gap stats feed the sequence checks.
   always @(negedge ff_clk) begin
      if (mon_on && !prbs_on) begin
         if (ff_en) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_extra: ff_en=1 ff_data=%0b with no bit expected at %0t", ff_data, $time);
            end else begin
               exp_b = sb.pop_front();
               if (ff_data !== exp_b) begin
                  errors++;
                  $display("FAIL sb_bit: ff_data=%0b expected %0b at %0t", ff_data, exp_b, $time);
               end
            end
            if (run_len == 0) begin
               runs++;
               last_gap = zero_len;
            end
            run_len++;
            en_total++;
            if (run_len > max_run) max_run = run_len;
            zero_len = 0;
         end else begin
            run_len = 0;
            zero_len++;
         end
         checks++;
         if (busy !== ff_en) begin
            errors++;
            $display("FAIL busy_vs_en: busy=%0b ff_en=%0b at %0t", busy, ff_en, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

`ifdef FF_PRBS_TEST_EN
   logic [6:0] lfsr_m;
   logic       hist [127];
`endif

   initial begin
      vecs[0] = '{8'hA5, 8'b1010_0101};
      vecs[1] = '{8'h00, 8'b0000_0000};
      vecs[2] = '{8'hFF, 8'b1111_1111};
      vecs[3] = '{8'h5A, 8'b0101_1010};
      vecs[4] = '{8'h81, 8'b1000_0001};

      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      tick(); tick(); tick();
      @(negedge ff_clk);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_ff_data", ff_data, 0);
      check("rst_ff_en", ff_en, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      tick();
      mon_on = 1'b1;

      // Single bytes: exactly 8 enabled cycles, MSB first, starting one cycle after the write.
      for (int v = 0; v < 5; v++) begin
         logic [7:0] bits;
         bits = vecs[v].exp_bits;
         wr(vecs[v].dat, 1'b1);
         @(negedge ff_clk);
         check("vec_pre_en", ff_en, 0);
         check("vec_level1", level, 1);
         for (int b = 0; b < 8; b++) begin
            @(negedge ff_clk);
            check("vec_en", ff_en, 1);
            check("vec_bit", ff_data, bits[7-b]);
         end
         @(negedge ff_clk);
         check("vec_post_en", ff_en, 0);
         check("vec_post_data", ff_data, 0);
         check("vec_post_empty", empty, 1);
         check("vec_post_level", level, 0);
      end

      // Three back-to-back bytes stream as one 24-cycle run.
      stats_clr();
      wr(8'h01, 1'b1); wr(8'h80, 1'b1); wr(8'hFF, 1'b1);
      @(negedge ff_clk);
      check("b2b_level", level, 2);
      wait_idle("b2b");
      check("b2b_runs", runs, 1);
      check("b2b_run_len", max_run, 24);

      // Fill to full, then overflow; the dropped byte must never be serialized.
      stats_clr();
      for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i), 1'b1);
      @(negedge ff_clk);
      check("fill_full", full, 1);
      check("fill_level", level, 8);
      check("fill_ovf_clear", overflow, 0);
      wr(8'hC9, 1'b0);
      @(negedge ff_clk);
      check("ovf_set", overflow, 1);
      check("ovf_level", level, 7);
      check("ovf_full", full, 0);
      wait_idle("ovf");
      check("ovf_sticky", overflow, 1);
      check("ovf_en_total", en_total, 72);
      check("ovf_sb_drained", sb.size(), 0);

      // Reset during the 4th bit of F0 with two bytes still queued.
      wr(8'hF0, 1'b1); wr(8'hAA, 1'b1); wr(8'h55, 1'b1);
      tick(); tick();
      reset = 1'b1;
      @(posedge ff_clk);
      sb.delete();
      #1 reset = 1'b0;
      @(negedge ff_clk);
      check("mrst_ff_en", ff_en, 0);
      check("mrst_ff_data", ff_data, 0);
      check("mrst_level", level, 0);
      check("mrst_empty", empty, 1);
      check("mrst_overflow", overflow, 0);
      check("mrst_busy", busy, 0);
      stats_clr();
      wr(8'h3C, 1'b1);
      wait_idle("mrst");
      check("mrst_runs", runs, 1);
      check("mrst_run_len", max_run, 8);
      check("mrst_sb_drained", sb.size(), 0);

      // Write on the same edge as the pop of the last queued byte: level holds, stream stays contiguous.
      stats_clr();
      wr(8'hC3, 1'b1);
      tick(); tick();
      wr(8'h96, 1'b1);
      tick(); tick(); tick(); tick(); tick();
      @(negedge ff_clk);
      check("same_edge_lvl_before", level, 1);
      wr(8'h69, 1'b1);
      @(negedge ff_clk);
      check("same_edge_lvl_after", level, 1);
      check("same_edge_empty", empty, 0);
      wait_idle("same_edge");
      check("same_edge_runs", runs, 1);
      check("same_edge_run_len", max_run, 24);

      // Write landing on the last-bit edge into an empty FIFO: exactly one idle cycle.
      stats_clr();
      wr(8'hE7, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      wr(8'h18, 1'b1);
      wait_idle("gap");
      check("gap_runs", runs, 2);
      check("gap_len", last_gap, 1);
      check("gap_en_total", en_total, 16);
      check("gap_sb_drained", sb.size(), 0);

`ifdef FF_PRBS_TEST_EN
      #1;
      prbs_on   = 1'b1;
      lfsr_m    = 7'h7F;
      prbs_mode = 1'b1;
      tick();
      for (int c = 0; c < 254; c++) begin
         @(negedge ff_clk);
         check("prbs_en", ff_en, 1);
         check("prbs_bit", ff_data, lfsr_m[6]);
         if (c < 7) check("prbs_seed_ones", ff_data, 1);
         if (c == 7) check("prbs_first_zero", ff_data, 0);
         if (c < 127) hist[c] = ff_data;
         else check("prbs_period", ff_data, hist[c-127]);
         lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
      end
      #1 prbs_mode = 1'b0;
      @(negedge ff_clk);
      check("prbs_exit_en", ff_en, 0);
      #1 prbs_on = 1'b0;
      stats_clr();
      wr(8'h5A, 1'b1);
      wait_idle("prbs_resume");
      check("prbs_resume_runs", runs, 1);
      check("prbs_resume_sb", sb.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
